// File: rtl/eth_rr_pkt_mux.sv
// Packet-granular N:1 AXI-Stream mux for the Ethernet TX path. It requests the external
// round-robin arbiter, locks onto the granted port and forwards that frame until tlast.
module eth_rr_pkt_mux #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int IDX_WIDTH  = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            s_tvalid,
    output logic [N-1:0]            s_tready,
    input  logic [N*DATA_WIDTH-1:0] s_tdata,
    input  logic [N*KEEP_WIDTH-1:0] s_tkeep,
    input  logic [N-1:0]            s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [KEEP_WIDTH-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic [N-1:0]            arb_req,
    input  logic [N-1:0]            arb_grant,
    output logic [IDX_WIDTH-1:0]    sel_port,
    output logic                    busy,
    output logic [31:0]             stat_pkt_cnt
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [IDX_WIDTH-1:0]   sel_q;
    logic                   m_tvalid_q;
    logic [DATA_WIDTH-1:0]  m_tdata_q;
    logic [KEEP_WIDTH-1:0]  m_tkeep_q;
    logic                   m_tlast_q;
    logic [31:0]            pkt_cnt_q;

    logic [DATA_WIDTH-1:0]  port_data [N];
    logic [KEEP_WIDTH-1:0]  port_keep [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign port_data[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign port_keep[gi] = s_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        end
    endgenerate

    // A multi-hot grant resolves to its lowest set bit.
    logic                 grant_any;
    logic [IDX_WIDTH-1:0] grant_idx;
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (arb_grant[i]) begin
                grant_any = 1'b1;
                grant_idx = IDX_WIDTH'(i);
            end
        end
    end

    logic out_free;
    logic src_hs;
    assign out_free = !m_tvalid_q || m_tready;
    assign src_hs   = (state_q == BUSY) && s_tvalid[sel_q] && out_free;

    always_comb begin
        s_tready = '0;
        if (state_q == BUSY) begin
            s_tready[sel_q] = out_free;
        end
    end

    // Requests are suppressed while reset is held so the arbiter sees a quiet bus.
    assign arb_req = (rst_n && state_q == IDLE) ? s_tvalid : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            if (m_tvalid_q && m_tready && m_tlast_q) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end

            // Load and drain may coincide, giving one beat per clock.
            if (src_hs) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= port_data[sel_q];
                m_tkeep_q  <= port_keep[sel_q];
                m_tlast_q  <= s_tlast[sel_q];
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end

            if (state_q == IDLE) begin
                if (grant_any && s_tvalid[grant_idx]) begin
                    sel_q   <= grant_idx;
                    state_q <= BUSY;
                end
            end else begin
                if (src_hs && s_tlast[sel_q]) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign m_tvalid     = m_tvalid_q;
    assign m_tdata      = m_tdata_q;
    assign m_tkeep      = m_tkeep_q;
    assign m_tlast      = m_tlast_q;
    assign sel_port     = sel_q;
    assign busy         = (state_q == BUSY);
    assign stat_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_eth_rr_pkt_mux.sv
// Bench for eth_rr_pkt_mux: per-port source queues, a registered round-robin arbiter model
// and an in-order scoreboard of accepted source beats against forwarded output beats.
`timescale 1ns/1ps
module tb_eth_rr_pkt_mux;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tlast;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic [IW-1:0]   sel_port;
    logic            busy;
    logic [31:0]     stat_pkt_cnt;

    eth_rr_pkt_mux #(.N(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .arb_req(arb_req), .arb_grant(arb_grant),
        .sel_port(sel_port), .busy(busy), .stat_pkt_cnt(stat_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    beat_t src_q [N][$];
    beat_t exp_q [$];
    beat_t out_log [$];

    bit           auto_arb = 1'b1;
    logic [N-1:0] manual_grant = '0;
    int           rr_last = N - 1;
    int           mready_mode = 0;
    int           hs_cnt [N];

    logic [N-1:0]  smp_req, smp_sready;
    logic          smp_mvalid, smp_busy;
    logic [IW-1:0] smp_sel;
    bit            stall_q = 1'b0;
    beat_t         stall_beat;

    function automatic beat_t mk(int port, int fr, int bt, bit last);
        beat_t b;
        b.data = {8'(port), 8'(fr), 8'(bt), 8'($urandom_range(255))};
        b.keep = 4'($urandom_range(1, 15));
        b.last = last;
        return b;
    endfunction

    task automatic push_frame(int port, int fr, int nb);
        for (int i = 0; i < nb; i++) src_q[port].push_back(mk(port, fr, i, i == nb - 1));
    endtask

    task automatic apply_inputs();
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0) begin
                s_tvalid[k]         = 1'b1;
                s_tdata[k*DW +: DW] = src_q[k][0].data;
                s_tkeep[k*KW +: KW] = src_q[k][0].keep;
                s_tlast[k]          = src_q[k][0].last;
            end else begin
                s_tvalid[k]         = 1'b0;
                s_tdata[k*DW +: DW] = '0;
                s_tkeep[k*KW +: KW] = '0;
                s_tlast[k]          = 1'b0;
            end
        end
    endtask

    // One clock: sample/score on the falling edge, then update sources and arbiter after the rising edge.
    task automatic tick();
        beat_t        ob, eb;
        logic [N-1:0] sel_oh, hs_mask;
        bit           found;
        int           p;
        @(negedge clk);
        smp_req    = arb_req;
        smp_sready = s_tready;
        smp_mvalid = m_tvalid;
        smp_busy   = busy;
        smp_sel    = sel_port;
        hs_mask    = s_tvalid & s_tready;
        ob         = {m_tdata, m_tkeep, m_tlast};

        sel_oh = '0;
        if (busy) sel_oh[sel_port] = 1'b1;
        checks++;
        if ((s_tready & ~sel_oh) !== '0) begin
            errors++;
            $display("FAIL isolation: s_tready=%b busy=%0b sel=%0d required no ready outside selected port", s_tready, busy, sel_port);
        end

        if (stall_q) begin
            checks++;
            if (m_tvalid !== 1'b1 || ob !== stall_beat) begin
                errors++;
                $display("FAIL hold: got v=%0b beat=%h required v=1 beat=%h", m_tvalid, ob, stall_beat);
            end
        end
        stall_q    = m_tvalid && !m_tready;
        stall_beat = ob;

        for (int k = 0; k < N; k++) begin
            if (hs_mask[k]) begin
                exp_q.push_back(src_q[k][0]);
                hs_cnt[k]++;
            end
        end

        if (m_tvalid && m_tready) begin
            out_log.push_back(ob);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: got beat=%h required no output beat", ob);
            end else begin
                eb = exp_q.pop_front();
                if (ob !== eb) begin
                    errors++;
                    $display("FAIL scoreboard: got beat=%h required %h", ob, eb);
                end
            end
        end

        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs_mask[k]) eb = src_q[k].pop_front();
        end
        if (!rst_n) begin
            arb_grant = '0;
        end else if (!auto_arb) begin
            arb_grant    = manual_grant;
            manual_grant = '0;
        end else if (arb_grant != '0) begin
            arb_grant = '0;
        end else begin
            found = 1'b0;
            for (int i = 1; i <= N; i++) begin
                p = (rr_last + i) % N;
                if (!found && smp_req[p]) begin
                    found        = 1'b1;
                    arb_grant    = '0;
                    arb_grant[p] = 1'b1;
                    rr_last      = p;
                end
            end
        end
        if (mready_mode == 1) m_tready = !m_tready;
        else                  m_tready = 1'b1;
        apply_inputs();
    endtask

    function automatic bit pending();
        bit any = (exp_q.size() > 0) || m_tvalid;
        for (int k = 0; k < N; k++) if (src_q[k].size() > 0) any = 1'b1;
        return any;
    endfunction

    task automatic drain(input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            tick();
            c++;
        end
        checks++;
        if (c >= maxc) begin
            errors++;
            $display("FAIL drain_timeout: got %0d cycles still pending required completion within %0d", c, maxc);
        end
    endtask

    task automatic test_reset();
        src_q[0].push_back(mk(0, 0, 0, 1'b1));
        apply_inputs();
        #1;
        checks++;
        if (arb_req !== 4'b0000 || s_tready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got arb_req=%b s_tready=%b required 0000 0000", arb_req, s_tready);
        end
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== '0) begin
            errors++;
            $display("FAIL reset_out: got v=%0b d=%h k=%h l=%0b required all zero", m_tvalid, m_tdata, m_tkeep, m_tlast);
        end
        checks++;
        if (busy !== 1'b0 || sel_port !== 2'd0 || stat_pkt_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b sel=%0d cnt=%0d required 0 0 0", busy, sel_port, stat_pkt_cnt);
        end
        void'(src_q[0].pop_front());
        apply_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        beat_t frame [$];
        out_log.delete();
        push_frame(2, 0, 3);
        frame = src_q[2];
        apply_inputs();
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 0) begin
                checks++;
                if (smp_req !== 4'b0100) begin
                    errors++;
                    $display("FAIL single_req: got arb_req=%b required 0100 in cycle 0", smp_req);
                end
            end
            checks++;
            if (smp_sready[2] !== (c >= 2 && c <= 4) || smp_busy !== (c >= 2 && c <= 4)) begin
                errors++;
                $display("FAIL single_ready: cycle %0d got s_tready[2]=%0b busy=%0b required %0b", c, smp_sready[2], smp_busy, (c >= 2 && c <= 4));
            end
            checks++;
            if (smp_mvalid !== (c >= 3 && c <= 5)) begin
                errors++;
                $display("FAIL single_mvalid: cycle %0d got %0b required %0b", c, smp_mvalid, (c >= 3 && c <= 5));
            end
        end
        checks++;
        if (out_log.size() != 3) begin
            errors++;
            $display("FAIL single_beats: got %0d beats required 3", out_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_log[i] !== frame[i]) begin
                    errors++;
                    $display("FAIL single_order: beat %0d got %h required %h", i, out_log[i], frame[i]);
                end
            end
        end
        checks++;
        if (stat_pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_cnt: got %0d required 1", stat_pkt_cnt);
        end
    endtask

    task automatic test_alternate();
        int exp_port [4] = '{0, 3, 0, 3};
        int exp_fr   [4] = '{0, 0, 1, 1};
        out_log.delete();
        rr_last = N - 1;
        push_frame(0, 0, 2);
        push_frame(0, 1, 2);
        push_frame(3, 0, 2);
        push_frame(3, 1, 2);
        apply_inputs();
        drain(200);
        checks++;
        if (out_log.size() != 8) begin
            errors++;
            $display("FAIL alt_beats: got %0d beats required 8", out_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_log[i].data[31:8] !== {8'(exp_port[i/2]), 8'(exp_fr[i/2]), 8'(i % 2)} || out_log[i].last !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL alt_order: beat %0d got tag=%h last=%0b required port %0d frame %0d beat %0d", i, out_log[i].data[31:8], out_log[i].last, exp_port[i/2], exp_fr[i/2], i % 2);
                end
            end
        end
        checks++;
        if (stat_pkt_cnt !== 32'd5) begin
            errors++;
            $display("FAIL alt_cnt: got %0d required 5", stat_pkt_cnt);
        end
    endtask

    task automatic test_backpressure();
        beat_t frame [$];
        out_log.delete();
        push_frame(1, 0, 4);
        frame = src_q[1];
        apply_inputs();
        mready_mode = 1;
        drain(200);
        mready_mode = 0;
        m_tready = 1'b1;
        checks++;
        if (out_log.size() != 4) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats required 4", out_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_log[i] !== frame[i]) begin
                    errors++;
                    $display("FAIL bp_order: beat %0d got %h required %h", i, out_log[i], frame[i]);
                end
            end
        end
        checks++;
        if (stat_pkt_cnt !== 32'd6) begin
            errors++;
            $display("FAIL bp_cnt: got %0d required 6", stat_pkt_cnt);
        end
    endtask

    task automatic test_spurious();
        auto_arb = 1'b0;
        push_frame(0, 2, 2);
        push_frame(3, 2, 1);
        apply_inputs();
        manual_grant = 4'b0010;
        tick();
        tick();
        tick();
        checks++;
        if (smp_busy !== 1'b0 || smp_sready !== 4'b0000) begin
            errors++;
            $display("FAIL spurious_idle: got busy=%0b s_tready=%b required 0 0000", smp_busy, smp_sready);
        end
        manual_grant = 4'b0001;
        tick();
        manual_grant = 4'b1000;
        tick();
        tick();
        tick();
        checks++;
        if (smp_busy !== 1'b1 || smp_sel !== 2'd0) begin
            errors++;
            $display("FAIL busy_grant: got busy=%0b sel=%0d required 1 0", smp_busy, smp_sel);
        end
        auto_arb = 1'b1;
        drain(200);
        checks++;
        if (stat_pkt_cnt !== 32'd8) begin
            errors++;
            $display("FAIL spurious_cnt: got %0d required 8", stat_pkt_cnt);
        end
    endtask

    task automatic test_multihot();
        auto_arb = 1'b0;
        push_frame(1, 3, 1);
        push_frame(3, 3, 1);
        apply_inputs();
        manual_grant = 4'b1010;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || sel_port !== 2'd1) begin
            errors++;
            $display("FAIL multihot: got busy=%0b sel=%0d required 1 1", busy, sel_port);
        end
        auto_arb = 1'b1;
        drain(200);
        checks++;
        if (stat_pkt_cnt !== 32'd10) begin
            errors++;
            $display("FAIL multihot_cnt: got %0d required 10", stat_pkt_cnt);
        end
    endtask

    task automatic test_reset_mid();
        beat_t frame [$];
        int c = 0;
        out_log.delete();
        push_frame(0, 4, 5);
        frame = src_q[0];
        apply_inputs();
        hs_cnt[0] = 0;
        while (hs_cnt[0] < 2 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (hs_cnt[0] < 2) begin
            errors++;
            $display("FAIL rst_setup: got %0d accepted beats required 2", hs_cnt[0]);
        end
        rst_n     = 1'b0;
        auto_arb  = 1'b0;
        arb_grant = '0;
        #1;
        exp_q.delete();
        stall_q = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000 || stat_pkt_cnt !== 32'd0 || arb_req !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid: got v=%0b busy=%0b rdy=%b cnt=%0d req=%b required 0 0 0000 0 0000", m_tvalid, busy, s_tready, stat_pkt_cnt, arb_req);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (smp_sready !== 4'b0000 || smp_mvalid !== 1'b0) begin
                errors++;
                $display("FAIL rst_nogrant: cycle %0d got s_tready=%b m_tvalid=%0b required 0000 0", i, smp_sready, smp_mvalid);
            end
        end
        auto_arb = 1'b1;
        out_log.delete();
        drain(200);
        checks++;
        if (out_log.size() != 3 || out_log[0] !== frame[2] || out_log[2] !== frame[4]) begin
            errors++;
            $display("FAIL rst_resume: got %0d beats required 3 beats starting at %h", out_log.size(), frame[2]);
        end
        checks++;
        if (stat_pkt_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rst_cnt: got %0d required 1", stat_pkt_cnt);
        end
    endtask

    initial begin
        s_tvalid  = '0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = '0;
        m_tready  = 1'b1;
        arb_grant = '0;
        for (int k = 0; k < N; k++) hs_cnt[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_spurious();
        test_multihot();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eth_rr_pkt_mux.md
# eth_rr_pkt_mux

Packet-granular N:1 AXI-Stream multiplexer for the Ethernet subsystem TX path. It drives the request vector of the companion round-robin arbiter and consumes its registered one-hot grant pulse. It locks onto the granted input port and forwards that port's frame beat-for-beat through a registered output stage until `tlast`, then releases. It also counts forwarded frames.

## Interface
- `N`, default 4: number of input ports; must be ≥2.
- `DATA_WIDTH`, default 256: tdata width in bits.
- `KEEP_WIDTH`, default DATA_WIDTH/8: tkeep width.
- `IDX_WIDTH`, default $clog2(N): port index width.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `s_tvalid`, input, N: per-port valid.
- `s_tready`, output, N: per-port ready.
- `s_tdata`, input, N*DATA_WIDTH: port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `s_tkeep`, input, N*KEEP_WIDTH: packed the same way as `s_tdata`.
- `s_tlast`, input, N: per-port end of frame.
- `m_tvalid`, `m_tready`, `m_tdata`, `m_tkeep`, `m_tlast`: output stream, widths 1/1/DATA_WIDTH/KEEP_WIDTH/1. `m_tready` is the only input of this group.
- `arb_req`, output, N: request vector to the arbiter.
- `arb_grant`, input, N: one-hot grant from the arbiter, registered on the arbiter side, one-cycle pulse.
- `sel_port`, output, IDX_WIDTH: index of the locked port. Valid while `busy`=1.
- `busy`, output, 1: asserted in state BUSY.
- `stat_pkt_cnt`, output, 32: count of frames whose `tlast` beat was accepted at `m_*`. Wraps modulo 2^32.

## Operation
- Two states: IDLE and BUSY.
- IDLE:
  - `arb_req = s_tvalid`, driven combinationally.
  - `s_tready = 0`.
  - If any bit of `arb_grant` is set, take the lowest set bit k.
  - If `s_tvalid[k]`=1: latch `sel_port<=k` and go to BUSY.
  - If `s_tvalid[k]`=0: ignore the grant and stay in IDLE.
- BUSY:
  - `arb_req = 0`. `arb_grant` is ignored.
  - `s_tready[sel_port] = !m_tvalid || m_tready`. All other `s_tready` bits are 0.
  - On a source handshake (`s_tvalid[sel] & s_tready[sel]`), load `m_tdata/m_tkeep/m_tlast` from the port slice and set `m_tvalid<=1`.
  - If the accepted beat has `s_tlast`=1, go to IDLE in the same edge.
- Output register:
  - `m_tvalid` clears on `m_tready` when no new beat is loaded.
  - A load and a drain in the same cycle give full throughput: one beat per clock.
- Port isolation: unselected ports are never readied. Their `tvalid` may stay high indefinitely without loss.
- Counter: `stat_pkt_cnt` increments on `m_tvalid & m_tready & m_tlast`.
- Input protocol: the source must hold valid until accepted. The block does not check this.

## Timing
- Reset values:
  - state IDLE, `sel_port`=0.
  - `m_tvalid`=0, `m_tdata`=0, `m_tkeep`=0, `m_tlast`=0.
  - `stat_pkt_cnt`=0.
  - `s_tready`=0 and `arb_req`=0 while `rst_n`=0.
- Reset mid-packet: the held output beat is dropped. The remainder of the source frame is presented again as a new frame after reset; upstream is responsible.
- Grant latency, with `s_tvalid[k]` rising in cycle 0 while IDLE:
  - Cycle 0: `arb_req[k]`=1.
  - Cycle 1: `arb_grant[k]`=1. BUSY is entered at the end of cycle 1.
  - Cycle 2: `s_tready[k]`=1 and the first beat is accepted.
  - Cycle 3: `m_tvalid`=1 with that beat.
- Frame end: `tlast` accepted in cycle t gives IDLE in cycle t+1 and a new grant no earlier than t+2. The next frame's first beat enters no earlier than t+3.
- Single-beat frame: accepted in cycle 2, state IDLE in cycle 3.
- `m_*` outputs are driven only by flops; there is no combinational path from inputs.
- `s_tready` depends combinationally on `m_tready`.

## Test plan
- Single port, 3-beat frame on port 2 with `m_tready`=1: `arb_req`=4'b0100 in cycle 0, `s_tready[2]` high in cycles 2–4, output beats in cycles 3–5 in order. `stat_pkt_cnt` ends at 1 and `busy` falls in cycle 5.
- Ports 0 and 3 both continuously valid with 2-beat frames, grants alternating 0,3,0,3: output frames alternate with no interleaving of beats. After 4 frames `stat_pkt_cnt`=4.
- Backpressure, `m_tready` toggling 1,0,1,0 during a 4-beat frame: no beat lost or duplicated, `m_tdata` stable while `m_tvalid & !m_tready`. Four beats observed.
- Spurious grant: `arb_grant`=4'b0010 with `s_tvalid[1]`=0 → state stays IDLE, `s_tready`=0. A grant during BUSY does not change `sel_port`.
- Multi-hot grant 4'b1010 with both ports valid → port 1 is selected.
- Reset asserted on beat 2 of a 5-beat frame: `m_tvalid`, `busy`, `s_tready` and `stat_pkt_cnt` are 0 immediately. After release, a new grant is needed before any beat is forwarded.
